// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbiter feeding a one-entry registered output stage.
// Optional burst locking is enabled by defining RR_ARB_MUX_LOCK_EN (adds in_last).
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               dbg_state,
  output logic [SELW-1:0]    dbg_ptr
);

  // Handshake: a beat moves on any rising edge where valid and ready are both
  // high; valid must not depend on ready, ready may depend on valid.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_n;
  logic [SELW-1:0] ptr, ptr_n;
  logic [SELW-1:0] gnt;
  logic            found;
  logic            space;
  logic            grant;
  logic [SELW:0]   idx;

`ifdef RR_ARB_MUX_LOCK_EN
  logic            locked;
  logic [SELW-1:0] lock_ch;
`endif

  assign out_valid = (state == FULL);
  assign space     = !out_valid || out_ready;
  assign dbg_state = (state == FULL);
  assign dbg_ptr   = ptr;

  // Priority search starting at ptr; idx carries one extra bit so ptr+k never overflows.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(N)) idx = idx - (SELW+1)'(N);
      if (!found && in_valid[idx[SELW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[SELW-1:0];
      end
    end
`ifdef RR_ARB_MUX_LOCK_EN
    if (locked) begin
      found = in_valid[lock_ch];
      gnt   = lock_ch;
    end
`endif
  end

  assign grant = found && space && !reset;

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    ptr_n = ptr;
    if (grant) ptr_n = (gnt == SELW'(N-1)) ? '0 : gnt + 1'b1;
  end

  always_comb begin
    state_n = state;
    if (grant) state_n = FULL;
    else if (out_valid && out_ready) state_n = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else if (grant) begin
      out_data <= in_data[int'(gnt)*WIDTH +: WIDTH];
      out_sel  <= gnt;
      ptr      <= ptr_n;
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  // A burst holds the arbiter on its channel until its last beat is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (grant) begin
      locked  <= !in_last[gnt];
      lock_ch <= gnt;
    end
  end
`endif

endmodule
